// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchical fan-out node.
package hier_node_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BCAST,
    ST_COLLECT,
    ST_RESP
  } hier_node_state_e;

  localparam int DEFAULT_CNT_W = 16;

  // True when the low `width` bits of `mask` are all set; callers zero-extend to 64.
  function automatic logic all_ones(input logic [63:0] mask, input int width);
    logic r_all;
    r_all = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < width && !mask[i]) r_all = 1'b0;
    end
    return r_all;
  endfunction

endpackage

// File: rtl/hier_node_timer.sv
// Transaction watchdog: clearable up-counter flagging the last allowed cycle.
module hier_node_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] r_count;

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (i_clr) begin
          r_count <= '0;
        end else if (i_en) begin
          r_count <= r_count + TW'(1);
        end
      end

      // Fires in the cycle whose increment would make the count reach TIMEOUT.
      assign o_tc = i_en && (r_count == TW'(TIMEOUT - 1));
    end else begin : g_tie
      logic w_unused;
      assign w_unused = ^{clk, rst, i_clr, i_en};
      assign o_tc     = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hier_fanout_node.sv
// Tree node: broadcasts one parent command to its children, gathers their
// completions and answers the parent with a single done/error pulse.
module hier_fanout_node
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 15,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [DATA_W-1:0]       up_data,
  input  logic [NUM_CHILDREN-1:0] child_en,
  output logic [NUM_CHILDREN-1:0] dn_valid,
  input  logic [NUM_CHILDREN-1:0] dn_ready,
  output logic [DATA_W-1:0]       dn_data,
  input  logic [NUM_CHILDREN-1:0] ch_done,
  output logic                    up_done,
  output logic                    up_err,
  output logic [NUM_CHILDREN-1:0] up_err_mask,
  output logic [CNT_W-1:0]        txn_count
);

  hier_node_state_e          r_state;
  logic [DATA_W-1:0]         r_dn_data;
  logic [NUM_CHILDREN-1:0]   r_acc;
  logic [NUM_CHILDREN-1:0]   r_done;
  logic                      r_up_done;
  logic                      r_up_err;
  logic [NUM_CHILDREN-1:0]   r_up_err_mask;
  logic [CNT_W-1:0]          r_txn_count;

  logic [NUM_CHILDREN-1:0]   w_dn_valid;
  logic [NUM_CHILDREN-1:0]   w_acc_next;
  logic [NUM_CHILDREN-1:0]   w_done_next;
  logic                      w_acc_full;
  logic                      w_done_full;
  logic                      w_accept;
  logic                      w_timer_en;
  logic                      w_tc;

  // Valid comes only from registered state and mask, never from dn_ready.
  assign w_dn_valid  = (r_state == ST_BCAST) ? ~r_acc : '0;
  assign w_acc_next  = r_acc | (w_dn_valid & dn_ready);
  // A completion counts only from a child whose command was accepted earlier.
  assign w_done_next = r_done | (ch_done & r_acc);
  assign w_acc_full  = all_ones(64'(w_acc_next), NUM_CHILDREN);
  assign w_done_full = all_ones(64'(w_done_next), NUM_CHILDREN);
  assign w_accept    = (r_state == ST_IDLE) && up_valid;
  assign w_timer_en  = (r_state == ST_BCAST) || (r_state == ST_COLLECT);

  hier_node_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_accept),
    .i_en (w_timer_en),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dn_data     <= '0;
      r_acc         <= '0;
      r_done        <= '0;
      r_up_done     <= 1'b0;
      r_up_err      <= 1'b0;
      r_up_err_mask <= '0;
      r_txn_count   <= '0;
    end else begin
      r_up_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (up_valid) begin
            r_dn_data <= up_data;
            r_acc     <= ~child_en;
            r_done    <= ~child_en;
            r_state   <= ST_BCAST;
          end
        end
        ST_BCAST: begin
          r_acc  <= w_acc_next;
          r_done <= w_done_next;
          if (w_acc_full && w_done_full) begin
            r_state <= ST_COLLECT;
          end else if (w_tc) begin
            r_state       <= ST_RESP;
            r_up_done     <= 1'b1;
            r_up_err      <= 1'b1;
            r_up_err_mask <= ~w_done_next;
          end else if (w_acc_full) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_done <= w_done_next;
          if (w_done_full) begin
            r_state       <= ST_RESP;
            r_up_done     <= 1'b1;
            r_up_err      <= 1'b0;
            r_up_err_mask <= '0;
          end else if (w_tc) begin
            r_state       <= ST_RESP;
            r_up_done     <= 1'b1;
            r_up_err      <= 1'b1;
            r_up_err_mask <= ~w_done_next;
          end
        end
        ST_RESP: begin
          r_state       <= ST_IDLE;
          r_up_err      <= 1'b0;
          r_up_err_mask <= '0;
          r_txn_count   <= r_txn_count + CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign up_ready    = (r_state == ST_IDLE);
  assign dn_valid    = w_dn_valid;
  assign dn_data     = r_dn_data;
  assign up_done     = r_up_done;
  assign up_err      = r_up_err;
  assign up_err_mask = r_up_err_mask;
  assign txn_count   = r_txn_count;

endmodule

// File: tb/tb_hier_fanout_node.sv
// Self-checking bench: each transaction is described by per-child accept and
// completion cycles, from which the expected outputs of every cycle follow.
module tb_hier_fanout_node;

  localparam int N  = 15;
  localparam int DW = 32;
  localparam int TO = 20;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic [N-1:0]  child_en;
  logic [N-1:0]  dn_valid;
  logic [N-1:0]  dn_ready;
  logic [DW-1:0] dn_data;
  logic [N-1:0]  ch_done;
  logic          up_done;
  logic          up_err;
  logic [N-1:0]  up_err_mask;
  logic [CW-1:0] txn_count;

  hier_fanout_node #(
    .NUM_CHILDREN(N),
    .DATA_W      (DW),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .child_en   (child_en),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .dn_data    (dn_data),
    .ch_done    (ch_done),
    .up_done    (up_done),
    .up_err     (up_err),
    .up_err_mask(up_err_mask),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle.
  logic          chk_en = 1'b0;
  logic          e_up_ready;
  logic [N-1:0]  e_dn_valid;
  logic [DW-1:0] e_dn_data;
  logic          e_up_done;
  logic          e_up_err;
  logic [N-1:0]  e_up_err_mask;
  logic [CW-1:0] e_txn_count;

  // Model state and per-transaction plan (cycle numbers relative to accept = 0).
  int            m_n;
  logic [DW-1:0] m_data;
  int            plan_a[N];
  int            plan_d[N];
  int            cur_c;
  int            obs_done_cyc;
  logic          obs_err;
  logic [N-1:0]  obs_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("up_ready",    64'(up_ready),    64'(e_up_ready));
      check("dn_valid",    64'(dn_valid),    64'(e_dn_valid));
      check("dn_data",     64'(dn_data),     64'(e_dn_data));
      check("up_done",     64'(up_done),     64'(e_up_done));
      check("up_err",      64'(up_err),      64'(e_up_err));
      check("up_err_mask", 64'(up_err_mask), 64'(e_up_err_mask));
      check("txn_count",   64'(txn_count),   64'(e_txn_count));
      if (up_done === 1'b1) begin
        obs_done_cyc = cur_c;
        obs_err      = up_err;
        obs_mask     = up_err_mask;
      end
    end
  end

  task automatic set_idle_exp();
    e_up_ready    = 1'b1;
    e_dn_valid    = '0;
    e_dn_data     = m_data;
    e_up_done     = 1'b0;
    e_up_err      = 1'b0;
    e_up_err_mask = '0;
    e_txn_count   = CW'(m_n);
  endtask

  // Response cycle and outcome from the plan: broadcast ends at the last
  // accept, collection starts after it, success once every enabled child is done.
  task automatic model_resp(input logic [N-1:0] en, output int r, output bit err,
                            output logic [N-1:0] mask);
    int a_max, d_max, c_done;
    a_max = 1;
    d_max = 0;
    mask  = '0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        if (plan_a[i] > a_max) a_max = plan_a[i];
        if (plan_d[i] == 0) d_max = 1000;
        else if (plan_d[i] > d_max) d_max = plan_d[i];
      end
    end
    c_done = (a_max + 1 > d_max) ? a_max + 1 : d_max;
    if (c_done <= TO) begin
      r   = c_done + 1;
      err = 1'b0;
    end else begin
      r   = TO + 1;
      err = 1'b1;
      for (int i = 0; i < N; i++)
        mask[i] = en[i] && (plan_d[i] == 0 || plan_d[i] > TO);
    end
  endtask

  task automatic run_txn(input logic [N-1:0] en, input logic [DW-1:0] data,
                         input int abort_c, input bit junk);
    int           r;
    bit           err;
    logic [N-1:0] mask, rdy, dn, ev;
    model_resp(en, r, err, mask);
    obs_done_cyc = -1;
    for (int c = 0; c <= r; c++) begin
      cur_c    = c;
      up_valid = (c == 0);
      up_data  = (c == 0) ? data : DW'($urandom);
      child_en = (c == 0) ? en : N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!en[i] || c == 0) rdy[i] = junk ? 1'($urandom) : 1'b0;
        else if (c < plan_a[i]) rdy[i] = 1'b0;
        else if (c == plan_a[i]) rdy[i] = 1'b1;
        else rdy[i] = junk ? 1'($urandom) : 1'b1;
        if (en[i] && plan_d[i] != 0 && c == plan_d[i]) dn[i] = 1'b1;
        else if (junk && (!en[i] || c <= plan_a[i] || (plan_d[i] != 0 && c > plan_d[i])))
          dn[i] = ($urandom_range(0, 3) == 0);
        else dn[i] = 1'b0;
        ev[i] = en[i] && c >= 1 && c <= plan_a[i] && c < r;
      end
      dn_ready      = rdy;
      ch_done       = dn;
      e_up_ready    = (c == 0);
      e_dn_valid    = ev;
      e_dn_data     = (c == 0) ? m_data : data;
      e_up_done     = (c == r);
      e_up_err      = (c == r) && err;
      e_up_err_mask = (c == r) ? mask : '0;
      e_txn_count   = CW'(m_n);
      if (c == abort_c) begin
        #2;
        rst    = 1'b1;
        m_n    = 0;
        m_data = '0;
        set_idle_exp();
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        dn_ready = '0;
        ch_done  = '0;
        rst      = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    m_n++;
    m_data   = data;
    up_valid = 1'b0;
    dn_ready = '0;
    ch_done  = '0;
    set_idle_exp();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cur_c    = -1;
      up_valid = 1'b0;
      up_data  = DW'($urandom);
      child_en = N'($urandom);
      dn_ready = N'($urandom);
      ch_done  = N'($urandom);
      set_idle_exp();
      @(posedge clk);
      #1;
    end
    dn_ready = '0;
    ch_done  = '0;
  endtask

  task automatic gen_plan(output logic [N-1:0] en);
    case ($urandom_range(0, 7))
      0:       en = '1;
      1:       en = '0;
      default: en = N'($urandom);
    endcase
    for (int i = 0; i < N; i++) begin
      plan_a[i] = 1 + $urandom_range(0, 4);
      plan_d[i] = ($urandom_range(0, 9) == 0) ? 0 : plan_a[i] + 1 + $urandom_range(0, 16);
    end
  endtask

  initial begin
    logic [N-1:0] en;
    rst      = 1'b1;
    up_valid = 1'b0;
    up_data  = '0;
    child_en = '0;
    dn_ready = '0;
    ch_done  = '0;
    m_n      = 0;
    m_data   = '0;
    cur_c    = -1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_up_ready",    64'(up_ready),    64'd1);
    check("rst_dn_valid",    64'(dn_valid),    64'd0);
    check("rst_dn_data",     64'(dn_data),     64'd0);
    check("rst_up_done",     64'(up_done),     64'd0);
    check("rst_up_err_mask", 64'(up_err_mask), 64'd0);
    check("rst_txn_count",   64'(txn_count),   64'd0);
    rst = 1'b0;
    set_idle_exp();
    chk_en = 1'b1;
    idle_cycles(2);

    // All ready, staggered completions one child per cycle.
    for (int i = 0; i < N; i++) begin plan_a[i] = 1; plan_d[i] = 2 + i; end
    run_txn('1, 32'hA5A5_0001, -1, 1'b0);
    check("stagger_done_cycle", 64'(obs_done_cyc), 64'd17);
    check("stagger_err",        64'(obs_err),      64'd0);
    check("stagger_txn_count",  64'(txn_count),    64'd1);

    // Children 3 and 7 stall five cycles; child 0 completes during broadcast.
    for (int i = 0; i < N; i++) begin plan_a[i] = 1; plan_d[i] = 8 + (i % 4); end
    plan_a[3] = 6;
    plan_a[7] = 6;
    plan_d[0] = 2;
    run_txn('1, 32'h1234_5678, -1, 1'b0);
    check("bp_done_cycle", 64'(obs_done_cyc), 64'd12);
    check("bp_err",        64'(obs_err),      64'd0);

    // Child 9 never completes.
    for (int i = 0; i < N; i++) begin plan_a[i] = 1; plan_d[i] = 2 + i; end
    plan_d[9] = 0;
    run_txn('1, 32'hDEAD_BEEF, -1, 1'b0);
    check("to_done_cycle", 64'(obs_done_cyc), 64'd21);
    check("to_err",        64'(obs_err),      64'd1);
    check("to_err_mask",   64'(obs_mask),     64'h0200);

    // Only children 0 and 2 enabled, then none.
    for (int i = 0; i < N; i++) begin plan_a[i] = 1; plan_d[i] = 0; end
    plan_a[2] = 2;
    plan_d[0] = 4;
    plan_d[2] = 6;
    run_txn(15'h0005, 32'h0000_0055, -1, 1'b1);
    check("mask_done_cycle", 64'(obs_done_cyc), 64'd7);
    run_txn('0, 32'h0000_00AA, -1, 1'b1);
    check("none_done_cycle", 64'(obs_done_cyc), 64'd3);
    check("none_err",        64'(obs_err),      64'd0);

    // Reset during collection, then a normal command.
    for (int i = 0; i < N; i++) begin plan_a[i] = 1; plan_d[i] = 2 + i; end
    run_txn('1, 32'hCAFE_0000, 4, 1'b0);
    check("abort_no_done", 64'(obs_done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    idle_cycles(3);
    check("abort_txn_count", 64'(txn_count), 64'd0);

    // Counter wrap at CNT_W = 2.
    for (int t = 0; t < 4; t++) begin
      gen_plan(en);
      run_txn(en, DW'($urandom), -1, 1'b1);
      if (t == 2) check("wrap_count_3", 64'(txn_count), 64'd3);
    end
    check("wrap_count_0", 64'(txn_count), 64'd0);

    // Randomized traffic with ignored noise on ready/done/enable.
    for (int t = 0; t < 60; t++) begin
      gen_plan(en);
      run_txn(en, DW'($urandom), -1, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hier_fanout_node.md
# hier_fanout_node

Parametrised hierarchy node for generated module trees. Accepts one command from its parent and broadcasts it to `NUM_CHILDREN` child ports with per-child valid/ready. It then collects one completion pulse from every enabled child and returns a single done/error response upward. Nodes chain recursively, so a tree of any depth or width is built from one block.

## Interface
- `NUM_CHILDREN`, 15: child port count, 1..64.
- `DATA_W`, 32: command payload width.
- `TIMEOUT`, 255: cycles allowed in BCAST+COLLECT before error; 0 disables the timeout.
- `CNT_W`, 16: width of the completed-transaction counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `up_valid`  in  1  parent command valid.
- `up_ready`  out  1  node can accept a command.
- `up_data`  in  `DATA_W`  parent command payload.
- `child_en`  in  `NUM_CHILDREN`  per-child enable; sampled at accept.
- `dn_valid`  out  `NUM_CHILDREN`  per-child command valid.
- `dn_ready`  in  `NUM_CHILDREN`  per-child accept.
- `dn_data`  out  `DATA_W`  broadcast payload, shared by all children.
- `ch_done`  in  `NUM_CHILDREN`  per-child single-cycle completion pulse.
- `up_done`  out  1  one-cycle response pulse to the parent.
- `up_err`  out  1  valid with `up_done`; 1 means timeout.
- `up_err_mask`  out  `NUM_CHILDREN`  valid with `up_done`; children that had not completed.
- `txn_count`  out  `CNT_W`  number of completed transactions; wraps.

## Operation
- **States:** IDLE, BCAST, COLLECT, RESP.
- **Reset values:** state IDLE. `up_ready`=1. `dn_valid`=0, `dn_data`=0. `up_done`=0, `up_err`=0, `up_err_mask`=0. `txn_count`=0. Internal masks and timer = 0.
- **IDLE:**
  - `up_ready`=1.
  - On `up_valid`: latch `up_data` into `dn_data`.
  - Set acc_mask = done_mask = ~`child_en`; disabled children count as finished.
  - Clear the timer and go to BCAST.
  - `ch_done` is ignored in IDLE.
- **BCAST:**
  - `dn_valid[i]` = ~acc_mask[i]; `dn_data` is held stable.
  - `dn_valid[i]&dn_ready[i]` sets acc_mask[i]; once set, `dn_valid[i]` drops the next cycle.
  - `ch_done[i]` sets done_mask[i] only if acc_mask[i] was already set.
  - When acc_mask is all ones (evaluated after this cycle's updates), go to COLLECT.
- **COLLECT:**
  - `dn_valid`=0.
  - `ch_done[i]&acc_mask[i]` sets done_mask[i].
  - When done_mask is all ones, go to RESP with err=0.
- **Timeout:**
  - The timer increments each cycle in BCAST or COLLECT.
  - When it reaches `TIMEOUT` (nonzero), go to RESP with err=1 and err_mask = ~done_mask.
  - Completion takes priority if both happen in the same cycle.
- **RESP:**
  - `up_done`=1 for exactly one cycle with `up_err` and `up_err_mask`.
  - `txn_count` increments on both success and error, wrapping to 0.
  - Next state IDLE.
- **Enable changes:** `child_en` changes outside IDLE have no effect.
- **Duplicate pulses:** a duplicate `ch_done` from an already-done child is ignored.

## Timing
- Accept in cycle 0 (IDLE) → BCAST from cycle 1.
- All `dn_ready` high in cycle 1 → COLLECT from cycle 2.
- Final `ch_done` in cycle k → `up_done` in cycle k+1 → `up_ready` again in cycle k+2.
- All children disabled: `up_done` in cycle 3 with `up_err`=0.
- `up_ready` is a registered state decode; no combinational path from `up_valid`.
- `dn_valid` depends only on registered state and mask; no path from `dn_ready`.
- Reset asserted mid-transaction:
  - Return to IDLE immediately; all outputs take reset values.
  - No `up_done` is emitted for the aborted command.
  - Children see `dn_valid` fall without a handshake; this is legal only under reset.

## Structure
- Package `hier_node_pkg`: state enum `hier_node_state_e`, default `CNT_W`, and a helper function for the all-ones reduction over a `NUM_CHILDREN` mask.
- Sub-module `hier_node_timer`: loadable up-counter with terminal-count flag; `$clog2(TIMEOUT+1)` bits; tied off when `TIMEOUT`=0.
- FSM, masks and counter live in `hier_fanout_node`.

## Test plan
- **All ready, staggered done:** `NUM_CHILDREN`=15, all enabled, `dn_ready`=all ones, `up_data`=0xA5A5_0001, `ch_done` pulsed one child per cycle.
  - Required: `dn_data`=0xA5A5_0001 held throughout; `up_done` one cycle after the 15th pulse; `up_err`=0; `txn_count`=1.
- **Backpressure:** children 3 and 7 hold `dn_ready` low for 5 cycles.
  - Required: only `dn_valid[3]` and `dn_valid[7]` stay high; state stays BCAST until both accept.
  - Required: an early `ch_done[0]` is recorded and not lost.
- **Timeout:** `TIMEOUT`=20; child 9 never pulses `ch_done`.
  - Required: `up_done` exactly 20 cycles after BCAST entry; `up_err`=1; `up_err_mask`=0x0200.
- **Masked children:** `child_en`=0x0005.
  - Required: only bits 0 and 2 of `dn_valid` assert; response after those two complete.
  - `child_en`=0 → `up_done` 3 cycles after accept.
- **Reset and wrap:**
  - Assert `rst` in COLLECT → outputs at reset values, no `up_done`, next command accepted normally.
  - `CNT_W`=2 with 4 transactions → `txn_count` wraps to 0.
